// File: rtl/shared_adder_pkg.sv
// Shared types and default constants for the shared adder arbiter.
package shared_adder_pkg;

  localparam int WIDTH_DEF = 20;
  localparam int NREQ_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/shared_adder_arb_rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted index and
// wraps, producing a one-hot grant (all zero when nothing is requested).
module rr_arbiter
  import shared_adder_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant
);

  logic found;
  int   idx;

  // Walk the requesters starting after last_grant; the first active one wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_adder_arb.sv
// One WIDTH-bit adder shared by NREQ requesters under round-robin arbitration.
// Each operation walks IDLE -> EXEC -> RESP; the result is held in RESP until
// the consumer takes it.
// Optional feature: define SHARED_ADDER_SAT_EN to clamp rsp_sum to all ones
// whenever the carry-out is set (rsp_cout still reports the raw carry).
module shared_adder_arb
  import shared_adder_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int NREQ  = NREQ_DEF,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  state_e             state_q;
  state_e             state_d;
  logic [IDW-1:0]     last_grant_q;
  logic [NREQ-1:0]    grant;
  logic               accept;

  logic [IDW-1:0]     sel_idx;
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;
  logic               sel_cin;

  logic [WIDTH-1:0]   a_p0;
  logic [WIDTH-1:0]   b_p0;
  logic               cin_p0;
  logic [IDW-1:0]     id_p0;
  logic [WIDTH:0]     sum_full_p0;

  // Result shaping: wrap modulo 2^WIDTH, or clamp on carry when enabled.
  function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH:0] full);
`ifdef SHARED_ADDER_SAT_EN
    return full[WIDTH] ? {WIDTH{1'b1}} : full[WIDTH-1:0];
`else
    return full[WIDTH-1:0];
`endif
  endfunction

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Grants are only offered in IDLE and never while reset is asserted.
  assign req_ready = (state_q == IDLE && rst_n) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);

  // Steer the granted requester's operands and index toward the latch.
  always_comb begin
    sel_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_idx = IDW'(i);
        sel_a   = req_a[i*WIDTH +: WIDTH];
        sel_b   = req_b[i*WIDTH +: WIDTH];
        sel_cin = req_cin[i];
      end
    end
  end

  // Next-state logic for the three-phase operation sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and round-robin pointer; the pointer moves only on an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IDW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && accept) begin
        last_grant_q <= sel_idx;
      end
    end
  end

  // Stage p0: operands captured on the accept edge.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && accept) begin
      a_p0   <= sel_a;
      b_p0   <= sel_b;
      cin_p0 <= sel_cin;
      id_p0  <= sel_idx;
    end
  end

  assign sum_full_p0 = {1'b0, a_p0} + {1'b0, b_p0} + {{WIDTH{1'b0}}, cin_p0};

  // Stage p1: adder output registered at the end of EXEC, held through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= '0;
    end else if (state_q == EXEC) begin
      rsp_sum  <= sat_sum(sum_full_p0);
      rsp_cout <= sum_full_p0[WIDTH];
      rsp_id   <= id_p0;
    end
  end

endmodule
